// File: rtl/ac_cmd_encoder.sv
// Air-conditioner command encoder: debounces the five panel keys, keeps the settings and
// publishes the 35/32-bit IR payloads with checksum, rate-limited by a holdoff counter.

module ac_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_deb, r_deb_q;
  logic [CW-1:0] r_cnt;

  // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_key};
      r_deb_q <= r_deb;
      if (r_sync[1] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_deb <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_deb & ~r_deb_q;
endmodule

module ac_cmd_encoder #(
  parameter int          DEBOUNCE_CYCLES = 2000000,
  parameter int          HOLDOFF_CYCLES  = 15000000,
  parameter logic [23:0] CONST35_LO      = 24'h000A50,
  parameter logic [27:0] CONST32_LO      = 28'h0040006
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_power,
  input  logic        key_mode,
  input  logic        key_temp_up,
  input  logic        key_temp_down,
  input  logic        key_fan,
  output logic [34:0] IR_in_data35,
  output logic [31:0] IR_in_data32,
  output logic        cmd_strobe,
  output logic        pending
);
  localparam int NK = 5;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_CALC, S_PUBLISH, S_HOLDOFF} state_t;

  state_t        r_state, w_nxt;
  logic [NK-1:0] w_keys, w_press, w_sel, r_sel, w_app_sel;
  logic          w_app_en;
  logic          r_power, w_power_n;
  logic [2:0]    r_mode, w_mode_n;
  logic [3:0]    r_temp, w_temp_n;
  logic [1:0]    r_fan, w_fan_n;
  logic [4:0]    w_sum;
  logic [34:0]   w_f35, r_frame35, r_out35;
  logic [31:0]   w_f32, r_frame32, r_out32;
  logic [HW-1:0] r_hold;
  logic          r_pending;

  // Bit 0 is the highest-priority key (power).
  assign w_keys = {key_fan, key_temp_down, key_temp_up, key_mode, key_power};

  ac_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NK-1:0] (
    .clk     (clk),
    .rst     (rst),
    .i_key   (w_keys),
    .o_press (w_press)
  );

  // Isolate the lowest set bit: the winning press; the rest are dropped.
  assign w_sel = w_press & (~w_press + NK'(1));

  assign w_app_sel = (r_state == S_HOLDOFF) ? w_sel : r_sel;
  assign w_app_en  = (r_state == S_UPDATE) || ((r_state == S_HOLDOFF) && (|w_sel));

  always_comb begin
    w_power_n = r_power;
    w_mode_n  = r_mode;
    w_temp_n  = r_temp;
    w_fan_n   = r_fan;
    if (w_app_sel[0]) begin
      w_power_n = ~r_power;
    end else if (r_power) begin
      if (w_app_sel[1]) w_mode_n = (r_mode == 3'd4) ? 3'd0 : r_mode + 3'd1;
      if (w_app_sel[2]) w_temp_n = (r_temp == 4'd14) ? 4'd14 : r_temp + 4'd1;
      if (w_app_sel[3]) w_temp_n = (r_temp == 4'd0) ? 4'd0 : r_temp - 4'd1;
      if (w_app_sel[4]) w_fan_n  = r_fan + 2'd1;
    end
  end

  assign w_sum = 5'(r_power) + 5'(r_mode) + 5'(r_temp) + 5'(r_fan);
  assign w_f35 = {r_mode, r_power, r_fan, 1'b0, r_temp, CONST35_LO};
  assign w_f32 = {w_sum[3:0], CONST32_LO};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (|w_sel) w_nxt = S_UPDATE;
      S_UPDATE:  w_nxt = (r_sel[0] | r_power) ? S_CALC : S_IDLE;
      S_CALC:    w_nxt = (r_hold == '0) ? S_PUBLISH : S_HOLDOFF;
      S_PUBLISH: w_nxt = S_IDLE;
      // Leave only on a quiet cycle so the frame already holds the latest settings.
      S_HOLDOFF: if ((r_hold == '0) && !(|w_sel)) w_nxt = S_PUBLISH;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_strobe   = (r_state == S_PUBLISH);
    IR_in_data35 = (r_state == S_PUBLISH) ? r_frame35 : r_out35;
    IR_in_data32 = (r_state == S_PUBLISH) ? r_frame32 : r_out32;
  end

  assign pending = r_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel     <= '0;
      r_power   <= 1'b0;
      r_mode    <= 3'd1;
      r_temp    <= 4'd10;
      r_fan     <= 2'd0;
      r_frame35 <= '0;
      r_frame32 <= '0;
      r_out35   <= '0;
      r_out32   <= '0;
      r_hold    <= '0;
      r_pending <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (|w_sel)) r_sel <= w_sel;
      if (w_app_en) begin
        r_power <= w_power_n;
        r_mode  <= w_mode_n;
        r_temp  <= w_temp_n;
        r_fan   <= w_fan_n;
      end
      if ((r_state == S_CALC) || (r_state == S_HOLDOFF)) begin
        r_frame35 <= w_f35;
        r_frame32 <= w_f32;
      end
      if ((r_state == S_CALC) && (r_hold != '0)) r_pending <= 1'b1;
      if (r_state == S_PUBLISH) begin
        r_out35   <= r_frame35;
        r_out32   <= r_frame32;
        r_pending <= 1'b0;
        r_hold    <= HW'(HOLDOFF_CYCLES);
      end else if (r_hold != '0) begin
        r_hold <= r_hold - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ac_cmd_encoder.sv
// Directed + randomized bench for ac_cmd_encoder against a settings-level reference model.

module tb_ac_cmd_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        key_power, key_mode, key_temp_up, key_temp_down, key_fan;
  logic [34:0] IR_in_data35;
  logic [31:0] IR_in_data32;
  logic        cmd_strobe, pending;

  ac_cmd_encoder #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(100)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_power     (key_power),
    .key_mode      (key_mode),
    .key_temp_up   (key_temp_up),
    .key_temp_down (key_temp_down),
    .key_fan       (key_fan),
    .IR_in_data35  (IR_in_data35),
    .IR_in_data32  (IR_in_data32),
    .cmd_strobe    (cmd_strobe),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, strobes = 0, glitches = 0;
  logic [34:0] prev35 = '0;
  logic [31:0] prev32 = '0;

  // Reference settings: power, mode, temperature offset, fan.
  int p, m, t, f;

  // Payloads may only move together with a strobe (reset excepted).
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      prev35 = IR_in_data35;
      prev32 = IR_in_data32;
    end else begin
      if (cmd_strobe) strobes++;
      else if (IR_in_data35 !== prev35 || IR_in_data32 !== prev32) glitches++;
      prev35 = IR_in_data35;
      prev32 = IR_in_data32;
    end
  end

  function automatic void model_reset();
    p = 0; m = 1; t = 10; f = 0;
  endfunction

  function automatic void apply(int k);
    if (k == 0) p = 1 - p;
    else if (p == 1) begin
      case (k)
        1: m = (m + 1) % 5;
        2: t = (t < 14) ? t + 1 : 14;
        3: t = (t > 0) ? t - 1 : 0;
        4: f = (f + 1) % 4;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [34:0] exp35();
    return {3'(m), 1'(p), 2'(f), 1'b0, 4'(t), 24'h000A50};
  endfunction

  function automatic logic [31:0] exp32();
    return {4'((p + m + t + f) % 16), 28'h0040006};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_power = v;
      1: key_mode = v;
      2: key_temp_up = v;
      3: key_temp_down = v;
      default: key_fan = v;
    endcase
  endtask

  task automatic press(input int k, input int hold);
    set_key(k, 1'b1);
    tick(hold);
    set_key(k, 1'b0);
    tick(8);
  endtask

  // One isolated press; expects a publish iff the model says the key takes effect.
  task automatic press_chk(input string tag, input int k, input int hold, input int settle);
    int s0;
    int e;
    s0 = strobes;
    e = (k == 0 || p == 1) ? 1 : 0;
    apply(k);
    press(k, hold);
    chk({tag, "_strobes"}, 64'(strobes), 64'(s0 + e));
    if (e == 1) begin
      chk({tag, "_d35"}, 64'(IR_in_data35), 64'(exp35()));
      chk({tag, "_d32"}, 64'(IR_in_data32), 64'(exp32()));
    end
    tick(settle);
  endtask

  initial begin
    int s0;
    int k;
    logic [10:0] top35;
    rst = 1'b0;
    key_power = 0; key_mode = 0; key_temp_up = 0; key_temp_down = 0; key_fan = 0;
    model_reset();
    tick(3);
    chk("rst_d35", 64'(IR_in_data35), 64'd0);
    chk("rst_d32", 64'(IR_in_data32), 64'd0);
    chk("rst_strobe", 64'(cmd_strobe), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    rst = 1'b1;
    tick(2);

    // Power on: the documented reset-settings frame.
    press_chk("t1", 0, 10, 0);
    top35 = IR_in_data35[34:24];
    chk("t1_top", 64'(top35), 64'(11'b001_1_00_0_1010));
    chk("t1_csum", 64'(IR_in_data32[31:28]), 64'hC);
    chk("t1_const", 64'(IR_in_data32[27:0]), 64'h0040006);
    tick(110);

    // Bounce: three-cycle highs are one short of the debounce window.
    s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      key_power = 1'b1; tick(3);
      key_power = 1'b0; tick(1);
    end
    key_power = 1'b1;
    tick(3);
    chk("t2_no_early", 64'(strobes), 64'(s0));
    tick(7);
    key_power = 1'b0;
    tick(8);
    apply(0);
    chk("t2_one", 64'(strobes), 64'(s0 + 1));
    chk("t2_d35", 64'(IR_in_data35), 64'(exp35()));
    chk("t2_d32", 64'(IR_in_data32), 64'(exp32()));
    tick(110);
    press_chk("t2_on", 0, 8, 110);

    // Temperature up to saturation; saturated presses still republish.
    for (int i = 0; i < 6; i++)
      press_chk($sformatf("t3_up%0d", i), 2, 8, (i == 5) ? 0 : 110);
    chk("t3_temp", 64'(IR_in_data35[27:24]), 64'd14);
    chk("t3_csum", 64'(IR_in_data32[31:28]), 64'h0);

    // Five mode presses inside the holdoff collapse into one publish.
    s0 = strobes;
    for (int i = 0; i < 5; i++) begin
      apply(1);
      press(1, 8);
      if (i == 1) chk("t4_pending_mid", 64'(pending), 64'd1);
    end
    chk("t4_no_early", 64'(strobes), 64'(s0));
    chk("t4_pending", 64'(pending), 64'd1);
    tick(40);
    chk("t4_one", 64'(strobes), 64'(s0 + 1));
    chk("t4_mode", 64'(IR_in_data35[34:32]), 64'd1);
    chk("t4_d35", 64'(IR_in_data35), 64'(exp35()));
    chk("t4_d32", 64'(IR_in_data32), 64'(exp32()));
    chk("t4_pending_clr", 64'(pending), 64'd0);
    tick(110);

    // Power off: other keys are ignored.
    press_chk("t5_off", 0, 8, 110);
    press_chk("t5_fan", 4, 8, 20);
    press_chk("t5_mode", 1, 8, 20);
    press_chk("t5_on", 0, 8, 110);

    // Random key sequence, each press isolated beyond the holdoff.
    for (int i = 0; i < 12; i++) begin
      k = int'($urandom_range(0, 4));
      press_chk($sformatf("rnd%0d_k%0d", i, k), k, int'($urandom_range(7, 12)), 110);
    end
    if (p == 0) press_chk("t6_on", 0, 8, 110);

    // Simultaneous temp_up and fan: only the higher-priority temp applies.
    s0 = strobes;
    key_temp_up = 1'b1; key_fan = 1'b1;
    tick(8);
    key_temp_up = 1'b0; key_fan = 1'b0;
    tick(8);
    apply(2);
    chk("t6_one", 64'(strobes), 64'(s0 + 1));
    chk("t6_d35", 64'(IR_in_data35), 64'(exp35()));
    chk("t6_d32", 64'(IR_in_data32), 64'(exp32()));

    // Reset in HOLDOFF with a pending change.
    press(1, 8);
    chk("t6_pending", 64'(pending), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_d35", 64'(IR_in_data35), 64'd0);
    chk("t6_rst_d32", 64'(IR_in_data32), 64'd0);
    chk("t6_rst_pending", 64'(pending), 64'd0);
    chk("t6_rst_strobe", 64'(cmd_strobe), 64'd0);
    tick(2);
    rst = 1'b1;
    model_reset();
    s0 = strobes;
    tick(150);
    chk("t6_quiet", 64'(strobes), 64'(s0));
    press_chk("t6_post", 0, 8, 10);

    chk("payload_glitch", 64'(glitches), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
